// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. The skid entry lets in_ready be a flop, so downstream back-pressure
// never forms a combinational path to upstream.
module pipe_stage_skid_reg #(
  parameter int unsigned      WIDTH       = 16,
  parameter bit               FLUSH_CLEAR = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_is_nop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_is_nop,
  output logic [1:0]       occupancy
);

  localparam int unsigned OCC_W = 2;

  // Main (M) and skid (S) entries
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             m_nop_q,   m_nop_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic             s_nop_q,   s_nop_d;

  // Registered status outputs
  logic             in_ready_q,  in_ready_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = m_valid_q & out_ready;

  // Next-state: flush first, then refill M (from S before new input), else park input in S
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_nop_d   = m_nop_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_nop_d   = s_nop_q;

    if (flush) begin
      m_valid_d = 1'b0;
      m_nop_d   = 1'b1;
      s_valid_d = 1'b0;
      s_nop_d   = 1'b1;
      if (FLUSH_CLEAR) begin
        m_data_d = RESET_DATA;
        s_data_d = RESET_DATA;
      end
    end else if (!m_valid_q || out_xfer) begin
      if (s_valid_q) begin
        // in_ready is low while S is valid, so no input can collide here
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_nop_d   = s_nop_q;
        s_valid_d = 1'b0;
        s_nop_d   = 1'b1;
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_nop_d   = in_is_nop;
      end else begin
        // Empty M always reads as a bubble so out_is_nop can be a plain flop
        m_valid_d = 1'b0;
        m_nop_d   = 1'b1;
      end
    end else if (in_xfer) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_nop_d   = in_is_nop;
    end

    in_ready_d  = !s_valid_d;
    occupancy_d = OCC_W'(m_valid_d) + OCC_W'(s_valid_d);
  end

  // State registers with asynchronous reset to empty bubbles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= RESET_DATA;
      m_nop_q     <= 1'b1;
      s_valid_q   <= 1'b0;
      s_data_q    <= RESET_DATA;
      s_nop_q     <= 1'b1;
      in_ready_q  <= 1'b1;
      occupancy_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_nop_q     <= m_nop_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_nop_q     <= s_nop_d;
      in_ready_q  <= in_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid_q;
  assign out_data   = m_data_q;
  assign out_is_nop = m_nop_q;
  assign occupancy  = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a FIFO reference model of the stage contents
// is updated as stimulus is applied and compared with the outputs each cycle.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush, in_valid, in_is_nop, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_is_nop;
  logic [15:0] out_data;
  logic [1:0]  occupancy;

  logic        b_flush, b_in_valid, b_in_is_nop, b_out_ready;
  logic [36:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_out_is_nop;
  logic [36:0] b_out_data;
  logic [1:0]  b_occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] mdl[$];  // {nop, data} of entries expected inside the stage

  pipe_stage_skid_reg #(.WIDTH(16), .FLUSH_CLEAR(1'b1), .RESET_DATA(16'h0000)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_nop(in_is_nop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_nop(out_is_nop), .occupancy(occupancy));

  pipe_stage_skid_reg #(.WIDTH(37), .FLUSH_CLEAR(1'b0), .RESET_DATA(37'h0)) u_w37 (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_is_nop(b_in_is_nop),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_is_nop(b_out_is_nop), .occupancy(b_occupancy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model, apply this cycle's inputs to the model, advance one edge
  task automatic cyc();
    int sz;
    sz = mdl.size();
    chk("occupancy", 64'(occupancy), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(sz < 2));
    chk("out_valid", 64'(out_valid), 64'(sz > 0));
    if (sz > 0) begin
      chk("out_data", 64'(out_data), 64'(mdl[0][15:0]));
      chk("out_is_nop", 64'(out_is_nop), 64'(mdl[0][16]));
    end else begin
      chk("out_is_nop_empty", 64'(out_is_nop), 64'd1);
    end
    if (flush) begin
      mdl.delete();
    end else begin
      if (out_ready && sz > 0) void'(mdl.pop_front());
      if (in_valid && sz < 2) mdl.push_back({in_is_nop, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_is_nop = 1'b0; out_ready = 1'b0; in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_is_nop = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

    // Reset state
    #16;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_is_nop", 64'(out_is_nop), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with both entries full
    in_valid = 1'b1; in_data = 16'hAAAA; cyc();
    in_data = 16'hBBBB; cyc();
    in_valid = 1'b0;
    chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_occupancy", 64'(occupancy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_is_nop", 64'(out_is_nop), 64'd1);
    chk("midrst_out_data", 64'(out_data), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    mdl.delete();
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i); cyc();
    end
    in_valid = 1'b0; cyc();
    cyc();

    // Back-pressure into the skid entry, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; cyc();
    in_data = 16'h2222; cyc();
    in_data = 16'h3333; cyc();
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    out_ready = 1'b0;

    // Flush while full, with a simultaneous offered input
    in_valid = 1'b1; in_data = 16'hC0DE; cyc();
    in_data = 16'hBEEF; cyc();
    in_data = 16'h4444; flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_data", 64'(out_data), 64'h0);
    chk("fl_occupancy", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    cyc(); cyc();
    out_ready = 1'b0;

    // Wide instance: nop payload, then flush without clearing the payload
    b_in_valid = 1'b1; b_in_is_nop = 1'b1; b_in_data = 37'h1_2345_6789;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_is_nop = 1'b0;
    chk("w37_out_valid", 64'(b_out_valid), 64'd1);
    chk("w37_out_is_nop", 64'(b_out_is_nop), 64'd1);
    chk("w37_out_data", 64'(b_out_data), 64'h1_2345_6789);
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    chk("w37_fl_out_valid", 64'(b_out_valid), 64'd0);
    chk("w37_fl_out_is_nop", 64'(b_out_is_nop), 64'd1);
    chk("w37_fl_out_data", 64'(b_out_data), 64'h1_2345_6789);
    chk("w37_fl_occupancy", 64'(b_occupancy), 64'd0);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) < 2);
      in_is_nop = ($urandom_range(0, 7) == 0);
      in_data   = 16'($urandom);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload of WIDTH bits plus a nop flag between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal and back-pressure never forms a combinational path across the stage.
- Synchronous flush converts both entries to bubbles. Stage wrappers pack their fields (pc, control word, operands, register IDs) into the payload bus.

Parameters:
- WIDTH, 16, payload width in bits; must be at least 1.
- FLUSH_CLEAR, 1. When 1, flush zeroes the stored payloads. When 0, payloads are left unchanged and only the valid bits clear.
- RESET_DATA, 0, payload value loaded into both entries at reset, or by flush when FLUSH_CLEAR=1.

Ports:
- clk  in  1  stage clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush request; highest priority.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage can accept a payload; registered output.
- in_data  in  WIDTH  upstream payload.
- in_is_nop  in  1  upstream payload is a bubble.
- out_valid  out  1  main entry holds a payload.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  WIDTH  main-entry payload.
- out_is_nop  out  1  downstream must treat this cycle as a bubble.
- occupancy  out  2  number of valid entries: 0, 1 or 2.

Behaviour:
- Storage is two entries, main (M) and skid (S). Each entry has a valid bit, a payload and a nop bit.
- Reset (reset_n=0, asynchronous):
  - M and S both invalid; both payloads = RESET_DATA; both nop bits = 1.
  - Outputs: in_ready=1, out_valid=0, out_is_nop=1, out_data=RESET_DATA, occupancy=0.
- Deassertion of reset_n is synchronised externally. The first active edge after reset follows the normal rules below.
- Output signals:
  - out_valid = M.valid.
  - out_data = M.payload.
  - out_is_nop = !M.valid | M.nop.
  - occupancy = M.valid + S.valid.
- Transfer definitions:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Priority on each edge when flush=0:
  - M is empty, or drains this cycle (output transfer):
    - If S is valid, M takes S and S becomes invalid. A simultaneous input transfer cannot occur, because in_ready=0 whenever S is valid.
    - Else, if an input transfer occurs, M takes the input.
    - Otherwise M becomes invalid.
  - M is full and does not drain, and an input transfer occurs: S takes the input.
  - in_ready on the next cycle = !S.valid after the update. It is never derived from out_ready in the same cycle.
- Ordering: strict FIFO. A payload in S always leaves before any later input.
- Latency: an input accepted at edge N appears on out_data after edge N when the stage was empty. Minimum latency is 1 cycle; there is no zero-cycle bypass.
- Throughput: 1 payload/cycle sustained while out_ready=1.
- Flush (flush=1 at an edge):
  - M and S both become invalid and both nop bits become 1.
  - Any input transfer in the same cycle is discarded.
  - Any output transfer in the same cycle is still considered consumed by downstream.
  - After the edge: out_is_nop=1, occupancy=0, in_ready=1.
  - FLUSH_CLEAR=1: both payloads become RESET_DATA.
- in_is_nop is stored with its payload. A valid payload with nop=1 still occupies an entry and obeys the handshake.
- Upstream must hold in_data and in_valid stable while in_valid=1 and in_ready=0. The stage does not check this.
- Boundary cases:
  - Full (occupancy=2): in_ready=0; further input is ignored.
  - Full with out_ready=1: M takes S, occupancy becomes 1, and in_ready returns to 1 on the next cycle.
  - Empty with out_ready=1: no action; out_is_nop=1.
  - Flush together with reset: reset dominates.
  - Flush while full: both entries lost; occupancy goes from 2 to 0 in one edge.
- The stall-only style of the older registers (a load/hold enable) is obtained by tying in_valid=1, deriving upstream stall from !in_ready, and driving out_ready from the downstream load enable.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill 2 entries with 16'hAAAA and 16'hBBBB, then pulse reset_n low for half a cycle between edges.
  - Required: immediately occupancy=0, out_valid=0, out_is_nop=1, out_data=16'h0000, in_ready=1.
- Streaming:
  - Stimulus: out_ready=1; present 16'h0001 through 16'h0008 on consecutive cycles.
  - Required: each value appears on out_data exactly 1 cycle after acceptance; in_ready stays 1; occupancy stays 1 throughout.
- Back-pressure and skid:
  - Stimulus: out_ready=0; send 16'h1111, then 16'h2222, then offer 16'h3333.
  - Required: occupancy=2, in_ready=0, and 16'h3333 is not taken.
  - Then raise out_ready for 3 cycles. Required: out_data sequence 16'h1111, 16'h2222, 16'h3333, with in_ready back to 1 one cycle after the first drain.
- Flush while full:
  - Stimulus: occupancy=2 holding 16'hC0DE and 16'hBEEF; assert flush together with in_valid=1 and in_data=16'h4444.
  - Required: next cycle occupancy=0, out_is_nop=1, out_data=16'h0000 (FLUSH_CLEAR=1), and 16'h4444 never appears.
- Nop payload and FLUSH_CLEAR=0:
  - Stimulus: WIDTH=37, FLUSH_CLEAR=0; send a payload with in_is_nop=1.
  - Required: out_valid=1 and out_is_nop=1.
  - Stimulus: then flush. Required: out_valid=0, out_data unchanged.
- Random soak:
  - Stimulus: 10k cycles of random in_valid, out_ready and flush (flush probability 2%).
  - Required: a scoreboard confirms in-order, loss-free, duplicate-free delivery between flushes; in_ready=0 only when occupancy=2.
